weighted_arbiter: RTL and testbench
===================================

WEIGHTED_ARBITER -- requirements
Module: weighted_arbiter

Interface
REQ-001 SHALL have parameter PORTS, default 4: number of requesters, 2..32.
REQ-002 SHALL have parameter TYPE, default "WEIGHTED": "PRIORITY", "ROUND_ROBIN" or "WEIGHTED".
REQ-003 SHALL have parameter BLOCK, default "NONE": "NONE", "REQUEST" or "ACKNOWLEDGE".
REQ-004 SHALL have parameter LSB_PRIORITY, default "LOW": "LOW" means index 0 wins ties; "HIGH" means index PORTS-1 wins ties.
REQ-005 SHALL have parameter WEIGHT_WIDTH, default 4: bits per port weight.
REQ-006 clk  input  1  clock; all logic on rising edge.
REQ-007 rst_n  input  1  reset; synchronous, active-low.
REQ-008 request  input  PORTS  per-port request.
REQ-009 acknowledge  input  PORTS  per-port beat/release strobe; used only when BLOCK="ACKNOWLEDGE".
REQ-010 weight  input  PORTS*WEIGHT_WIDTH  port i weight in bits [i*WEIGHT_WIDTH +: WEIGHT_WIDTH]; used only when TYPE="WEIGHTED".
REQ-011 grant  output  PORTS  one-hot or zero; registered.
REQ-012 grant_valid  output  1  high iff grant is non-zero.
REQ-013 grant_encoded  output  $clog2(PORTS)  index of the granted port; 0 when grant_valid is low.
REQ-014 grant_last  output  1  high while grant_valid is high and the credit count is 0.

Function
REQ-015 Beat definition: BLOCK="ACKNOWLEDGE": a granted cycle with acknowledge[g] high. Otherwise: every granted cycle.
REQ-016 Credit count: loaded with weight[winner] when a new grant is issued; weight is sampled only at grant time; the count decrements on each beat while non-zero.
REQ-017 TYPE="WEIGHTED": the grant SHALL be released on a beat with the count equal to 0, giving the port weight+1 beats. Weight 0 gives 1 beat.
REQ-018 TYPE="PRIORITY" or "ROUND_ROBIN" with BLOCK="NONE": the grant SHALL be released on every beat (re-arbitration every cycle).
REQ-019 TYPE="PRIORITY" or "ROUND_ROBIN" with BLOCK="REQUEST": the grant SHALL be held until request[g] is low.
REQ-020 TYPE="PRIORITY" or "ROUND_ROBIN" with BLOCK="ACKNOWLEDGE": the grant SHALL be held until acknowledge[g] is high.
REQ-021 BLOCK="NONE" or "REQUEST": request[g] low SHALL release the grant immediately in that cycle, regardless of remaining credit.
REQ-022 BLOCK="ACKNOWLEDGE": request[g] low SHALL NOT release the grant; only the acknowledge rules release it.
REQ-023 Arbitration: on release, or when idle, a winner SHALL be chosen from the current-cycle request and registered. The new grant appears the next cycle, with no idle bubble between back-to-back grants.
REQ-024 PRIORITY selection: the fixed-priority winner per LSB_PRIORITY; the released port may win again.
REQ-025 ROUND_ROBIN and WEIGHTED selection: a mask pointer SHALL give priority to ports after the last granted index, in LSB_PRIORITY order, wrapping around. If no masked port requests, unmasked fixed priority applies, so a sole requester is re-granted.
REQ-026 When no port requests at a release, the block SHALL go idle: grant=0, grant_valid=0, grant_encoded=0, grant_last=0 next cycle; the mask pointer is retained.
REQ-027 Latency: request rising in an idle cycle N SHALL give the grant in cycle N+1.
REQ-028 Changes to the weight input during a grant SHALL NOT affect the current grant.
REQ-029 Invariants: grant SHALL be one-hot or zero; (1<<grant_encoded)==grant whenever grant_valid is high; grant_last implies grant_valid.

Reset
REQ-030 rst_n low at a rising edge SHALL clear grant, grant_valid, grant_encoded, grant_last, the credit count and the mask pointer to 0. This holds mid-grant and regardless of request or acknowledge.
REQ-031 The first arbitration after reset SHALL use plain fixed priority per LSB_PRIORITY.

Verification
REQ-032 Reset: rst_n=0 with request=4'b1111 -> grant=0, grant_valid=0, grant_encoded=0 in every cycle; release with request held -> grant=4'b0001 one cycle later.
REQ-033 WEIGHTED/NONE, PORTS=4, weights {0,2,0,1} for ports {0,1,2,3}, request=4'b1111 held -> repeating grant_encoded 0,1,1,1,2,3,3,0,...; grant_last high on the final cycle of each port.
REQ-034 ROUND_ROBIN/ACKNOWLEDGE, request=4'b0101, acknowledge pulsed on the granted port every second cycle -> grants alternate 0,2,0,2, each held exactly 2 cycles.
REQ-035 PRIORITY/REQUEST: request=4'b0010, then 4'b0011 -> grant stays 4'b0010 until request[1] drops; grant=4'b0001 the next cycle.
REQ-036 WEIGHTED/ACKNOWLEDGE, weight[2]=3, request=4'b0100: request drops after 1 ack -> grant held; released only after the 4th acknowledge; weight changed to 0 mid-grant -> no effect.
REQ-037 Mid-grant reset: in REQ-033 traffic, rst_n=0 during port 1's second cycle -> all outputs 0 next cycle; after release the sequence restarts at port 0.

Source files
------------

// File: rtl/weighted_arbiter.sv
// weighted_arbiter
//   Picks one requester per arbitration and holds its grant for a number of
//   beats set by TYPE/BLOCK. PRIORITY picks by fixed order. ROUND_ROBIN and
//   WEIGHTED favour the ports after the last granted one. WEIGHTED also gives
//   each grant weight+1 beats, using a credit count loaded when the grant is
//   issued.
// Ports
//   clk, rst_n      clock, synchronous active-low reset
//   request         per-port request
//   acknowledge     per-port beat/release strobe (BLOCK="ACKNOWLEDGE" only)
//   weight          per-port credit weight, port i at [i*WEIGHT_WIDTH +: WEIGHT_WIDTH]
//   grant           registered one-hot grant, zero when idle
//   grant_valid     grant is non-zero
//   grant_encoded   index of the granted port, 0 when idle
//   grant_last      granted and the credit count has reached 0
module weighted_arbiter #(
  parameter int    PORTS        = 4,
  parameter string TYPE         = "WEIGHTED",
  parameter string BLOCK        = "NONE",
  parameter string LSB_PRIORITY = "LOW",
  parameter int    WEIGHT_WIDTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [PORTS-1:0]              request,
  input  logic [PORTS-1:0]              acknowledge,
  input  logic [PORTS*WEIGHT_WIDTH-1:0] weight,
  output logic [PORTS-1:0]              grant,
  output logic                          grant_valid,
  output logic [$clog2(PORTS)-1:0]      grant_encoded,
  output logic                          grant_last
);

  localparam int IDX_W       = $clog2(PORTS);
  localparam bit IS_WEIGHTED = (TYPE == "WEIGHTED");
  localparam bit USE_MASK    = (TYPE != "PRIORITY");
  localparam bit BLK_ACK     = (BLOCK == "ACKNOWLEDGE");
  localparam bit BLK_REQ     = (BLOCK == "REQUEST");
  localparam bit MSB_WINS    = (LSB_PRIORITY == "HIGH");

  logic [PORTS-1:0]        grant_q, grant_d;
  logic [IDX_W-1:0]        enc_q, enc_d;
  logic [WEIGHT_WIDTH-1:0] credit_q, credit_d;
  // Set bits mark the ports that come after the last granted index in
  // priority order. An all-zero mask (after reset) means plain fixed priority.
  logic [PORTS-1:0]        mask_q, mask_d;

  logic             req_g, ack_g, beat, release_g, arbitrate;
  logic [PORTS-1:0] masked_req;
  logic [IDX_W-1:0] winner;

  function automatic logic [IDX_W-1:0] pick(input logic [PORTS-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    // Scan from lowest to highest priority, so the last hit is the winner.
    for (int i = 0; i < PORTS; i++) begin
      if (MSB_WINS) begin
        if (v[i]) idx = IDX_W'(i);
      end else begin
        if (v[PORTS-1-i]) idx = IDX_W'(PORTS-1-i);
      end
    end
    return idx;
  endfunction

  always_comb begin
    req_g = |(grant_q & request);
    ack_g = |(grant_q & acknowledge);
    beat  = grant_valid && (BLK_ACK ? ack_g : 1'b1);

    if (IS_WEIGHTED)  release_g = beat && (credit_q == '0);
    else if (BLK_ACK) release_g = ack_g;
    else if (BLK_REQ) release_g = !req_g;
    else              release_g = beat;
    // Without acknowledge blocking, a withdrawn request ends the grant at
    // once, whatever credit is left.
    if (!BLK_ACK && !req_g) release_g = 1'b1;

    arbitrate  = !grant_valid || release_g;
    masked_req = USE_MASK ? (request & mask_q) : '0;
    winner     = (|masked_req) ? pick(masked_req) : pick(request);

    grant_d  = grant_q;
    enc_d    = enc_q;
    credit_d = credit_q;
    mask_d   = mask_q;

    if (beat && (credit_q != '0)) credit_d = credit_q - WEIGHT_WIDTH'(1);

    if (arbitrate) begin
      if (|request) begin
        grant_d  = '0;
        enc_d    = winner;
        credit_d = '0;
        for (int i = 0; i < PORTS; i++) begin
          if (IDX_W'(i) == winner) begin
            grant_d[i] = 1'b1;
            credit_d   = weight[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
          end
          mask_d[i] = MSB_WINS ? (IDX_W'(i) < winner) : (IDX_W'(i) > winner);
        end
      end else begin
        // Idle: the mask is kept so round-robin fairness survives gaps.
        grant_d  = '0;
        enc_d    = '0;
        credit_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grant_q  <= '0;
      enc_q    <= '0;
      credit_q <= '0;
      mask_q   <= '0;
    end else begin
      grant_q  <= grant_d;
      enc_q    <= enc_d;
      credit_q <= credit_d;
      mask_q   <= mask_d;
    end
  end

  assign grant         = grant_q;
  assign grant_valid   = |grant_q;
  assign grant_encoded = enc_q;
  assign grant_last    = grant_valid && (credit_q == '0);

endmodule

// File: tb/tb_weighted_arbiter.sv
module tb_weighted_arbiter;

  localparam int P  = 4;
  localparam int WW = 4;
  localparam int N  = 4;

  logic        clk, rst_n;
  logic [3:0]  request, acknowledge;
  logic [15:0] weight;

  logic [3:0] gnt [N];
  logic [1:0] enc [N];
  logic       gv  [N];
  logic       gl  [N];

  // Instance configurations: type 0=PRIORITY 1=ROUND_ROBIN 2=WEIGHTED,
  // block 0=NONE 1=REQUEST 2=ACKNOWLEDGE, hi=1 means index P-1 wins ties.
  int typ_c [N] = '{2, 1, 0, 2};
  int blk_c [N] = '{0, 2, 1, 2};
  bit hi_c  [N] = '{0, 0, 0, 1};

  weighted_arbiter #(.PORTS(P), .TYPE("WEIGHTED"), .BLOCK("NONE"),
                     .LSB_PRIORITY("LOW"), .WEIGHT_WIDTH(WW)) u0 (
    .clk(clk), .rst_n(rst_n), .request(request), .acknowledge(acknowledge),
    .weight(weight), .grant(gnt[0]), .grant_valid(gv[0]),
    .grant_encoded(enc[0]), .grant_last(gl[0]));

  weighted_arbiter #(.PORTS(P), .TYPE("ROUND_ROBIN"), .BLOCK("ACKNOWLEDGE"),
                     .LSB_PRIORITY("LOW"), .WEIGHT_WIDTH(WW)) u1 (
    .clk(clk), .rst_n(rst_n), .request(request), .acknowledge(acknowledge),
    .weight(weight), .grant(gnt[1]), .grant_valid(gv[1]),
    .grant_encoded(enc[1]), .grant_last(gl[1]));

  weighted_arbiter #(.PORTS(P), .TYPE("PRIORITY"), .BLOCK("REQUEST"),
                     .LSB_PRIORITY("LOW"), .WEIGHT_WIDTH(WW)) u2 (
    .clk(clk), .rst_n(rst_n), .request(request), .acknowledge(acknowledge),
    .weight(weight), .grant(gnt[2]), .grant_valid(gv[2]),
    .grant_encoded(enc[2]), .grant_last(gl[2]));

  weighted_arbiter #(.PORTS(P), .TYPE("WEIGHTED"), .BLOCK("ACKNOWLEDGE"),
                     .LSB_PRIORITY("HIGH"), .WEIGHT_WIDTH(WW)) u3 (
    .clk(clk), .rst_n(rst_n), .request(request), .acknowledge(acknowledge),
    .weight(weight), .grant(gnt[3]), .grant_valid(gv[3]),
    .grant_encoded(enc[3]), .grant_last(gl[3]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [3:0] g;
    logic [1:0] e;
    logic       v;
    logic       l;
  } exp_t;

  exp_t sb [N][$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: owner index (-1 idle), beats of credit left, last owner.
  int own [N];
  int cred [N];
  int lastp [N];

  function automatic void chk(string nm, int k, logic [7:0] act, logic [7:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s u%0d: got %0h want %0h at %0t", nm, k, act, expv, $time);
    end
  endfunction

  task automatic model_step(input int k, input bit rst, input logic [3:0] req,
                            input logic [3:0] ack, input logic [15:0] wt);
    bit arb;
    bit beat;
    int g, w, start, idx;
    if (!rst) begin
      own[k] = -1; cred[k] = 0; lastp[k] = -1;
      return;
    end
    arb = 1'b1;
    if (own[k] >= 0) begin
      g    = own[k];
      beat = (blk_c[k] == 2) ? ack[g] : 1'b1;
      if (typ_c[k] == 2)      arb = beat && (cred[k] == 0);
      else if (blk_c[k] == 0) arb = beat;
      else if (blk_c[k] == 1) arb = !req[g];
      else                    arb = ack[g];
      if (blk_c[k] != 2 && !req[g]) arb = 1'b1;
      if (beat && cred[k] > 0) cred[k]--;
    end
    if (!arb) return;
    if (req == 4'b0) begin
      own[k] = -1; cred[k] = 0;
      return;
    end
    // Circular search starting just after the last owner in priority order.
    if (typ_c[k] == 0 || lastp[k] < 0) start = hi_c[k] ? P - 1 : 0;
    else start = hi_c[k] ? lastp[k] - 1 : lastp[k] + 1;
    w = -1;
    for (int s = 0; s < P; s++) begin
      idx = hi_c[k] ? ((start - s + 2 * P) % P) : ((start + s) % P);
      if (w < 0 && req[idx]) w = idx;
    end
    own[k]   = w;
    cred[k]  = int'(wt[w*WW +: WW]);
    lastp[k] = w;
  endtask

  task automatic cycle(input bit r, input logic [3:0] rq, input logic [3:0] ak,
                       input logic [15:0] wt);
    exp_t x;
    @(negedge clk);
    rst_n = r; request = rq; acknowledge = ak; weight = wt;
    for (int k = 0; k < N; k++) begin
      model_step(k, r, rq, ak, wt);
      x.v = (own[k] >= 0);
      x.g = x.v ? 4'(1 << own[k]) : 4'b0;
      x.e = x.v ? 2'(own[k]) : 2'b0;
      x.l = x.v && (cred[k] == 0);
      sb[k].push_back(x);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < N; k++) begin
        if (sb[k].size() > 0) begin
          e = sb[k].pop_front();
          chk("grant", k, 8'(gnt[k]), 8'(e.g));
          chk("grant_encoded", k, 8'(enc[k]), 8'(e.e));
          chk("grant_valid", k, 8'(gv[k]), 8'(e.v));
          chk("grant_last", k, 8'(gl[k]), 8'(e.l));
        end
      end
    end
  end

  int seq_e [8] = '{0, 1, 1, 1, 2, 3, 3, 0};
  int seq_l [8] = '{1, 0, 0, 1, 1, 0, 1, 1};

  initial begin
    logic [3:0] ak;
    rst_n = 1'b0; request = '0; acknowledge = '0; weight = '0;
    for (int k = 0; k < N; k++) begin
      own[k] = -1; cred[k] = 0; lastp[k] = -1;
    end

    // Reset held with all requesting, then weighted rotation {0,2,0,1}.
    repeat (3) cycle(1'b0, 4'hF, 4'h0, 16'h1020);
    for (int i = 0; i <= 8; i++) begin
      cycle(1'b1, 4'hF, 4'h0, 16'h1020);
      if (i >= 1) begin
        chk("seq_encoded", 0, 8'(enc[0]), 8'(seq_e[i-1]));
        chk("seq_last", 0, 8'(gl[0]), 8'(seq_l[i-1]));
      end
    end
    repeat (8) cycle(1'b1, 4'hF, 4'h0, 16'h1020);

    // Reset during port 1's second cycle, then restart from port 0.
    repeat (2) cycle(1'b0, 4'hF, 4'h0, 16'h1020);
    repeat (3) cycle(1'b1, 4'hF, 4'h0, 16'h1020);
    cycle(1'b0, 4'hF, 4'h0, 16'h1020);
    repeat (10) cycle(1'b1, 4'hF, 4'h0, 16'h1020);

    // Round-robin with acknowledge on the granted port every second cycle.
    repeat (2) cycle(1'b0, 4'h0, 4'h0, 16'h0);
    for (int i = 0; i < 16; i++) begin
      ak = (i % 2 == 1 && own[1] >= 0) ? 4'(1 << own[1]) : 4'h0;
      cycle(1'b1, 4'b0101, ak, 16'h0);
    end

    // Fixed priority with request blocking.
    repeat (2) cycle(1'b0, 4'h0, 4'h0, 16'h0);
    repeat (3) cycle(1'b1, 4'b0010, 4'h0, 16'h0);
    repeat (4) cycle(1'b1, 4'b0011, 4'h0, 16'h0);
    repeat (3) cycle(1'b1, 4'b0001, 4'h0, 16'h0);

    // Weighted with acknowledge: weight[2]=3, request drops, weight zeroed.
    repeat (2) cycle(1'b0, 4'h0, 4'h0, 16'h0);
    repeat (2) cycle(1'b1, 4'b0100, 4'h0, 16'h0300);
    cycle(1'b1, 4'b0100, 4'b0100, 16'h0300);
    for (int i = 0; i < 10; i++)
      cycle(1'b1, 4'b0000, (i % 2 == 1) ? 4'b0100 : 4'b0000, 16'h0000);

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++)
      cycle(($urandom_range(0, 49) != 0), 4'($urandom), 4'($urandom), 16'($urandom));

    repeat (2) @(negedge clk);
    for (int k = 0; k < N; k++) begin
      n_cmp++;
      if (sb[k].size() != 0) begin
        n_bad++;
        $display("FAIL drain u%0d: got %0d left want 0", k, sb[k].size());
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
